veda_ifetch: RTL and testbench

Instruction fetch unit for the VEDA core: the requesting side of the combinational instruction-memory read port. It owns the program counter and drives a byte address to instruction memory. It captures the returned word together with its opcode (`ctr`) and function field (`funcode`) into a 2-entry buffer, and hands entries to decode over a valid/ready handshake. It also handles redirects (branch/jump), stalls, and the halt word `32'hFC000000` (opcode `6'b111111`).

---
 rtl/veda_ifetch.sv | 142 ++++++++++++++
 tb/tb_veda_ifetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/veda_ifetch.sv
// VEDA instruction fetch: PC, 2-entry fetch buffer, redirect and halt handling.
// Optional bounds check enabled by defining VEDA_IFETCH_BOUNDS_EN.
module veda_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INIT_ADDR  = 32'hFFFF_FFFC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic [5:0]  imem_ctr,
    input  logic [5:0]  imem_funcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  out_ctr,
    output logic [5:0]  out_funcode,
    output logic        halted,
    output logic        fault
);

    localparam logic [1:0]  ST_INIT   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_HALT   = 2'd2;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [5:0]  HALT_CTR  = 6'b111111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  ctr;
        logic [5:0]  funcode;
    } entry_t;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      e0_q, e0_d, e1_q, e1_d;
    logic        halted_q, halted_d;
    entry_t      new_e;
    logic        redir, push, pop;

    // out_valid/out_ready: the head transfers on any cycle both are high;
    // out_valid never depends combinationally on out_ready.
    assign redir = redirect_valid && (state_q != ST_INIT);
    assign pop   = out_valid && out_ready;
    assign push  = (state_q == ST_RUN) && (count_q < 2'd2) && !redir;

`ifdef VEDA_IFETCH_BOUNDS_EN
    logic fault_q, fault_d;
    logic oob;
    assign oob = (pc_q[31:2] >= 30'(IMEM_WORDS));
    always_comb begin
        new_e = '{instr: imem_instr, pc: pc_q, ctr: imem_ctr, funcode: imem_funcode};
        if (oob) begin
            new_e = '{instr: HALT_WORD, pc: pc_q, ctr: HALT_CTR, funcode: 6'd0};
        end
    end
    assign fault = fault_q;
`else
    assign new_e = '{instr: imem_instr, pc: pc_q, ctr: imem_ctr, funcode: imem_funcode};
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        e0_d     = e0_q;
        e1_d     = e1_q;
        halted_d = halted_q;
`ifdef VEDA_IFETCH_BOUNDS_EN
        fault_d  = fault_q;
`endif
        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
        end else if (redir) begin
            count_d  = 2'd0;
            pc_d     = {redirect_pc[31:2], 2'b00};
            state_d  = ST_RUN;
            halted_d = 1'b0;
`ifdef VEDA_IFETCH_BOUNDS_EN
            fault_d  = 1'b0;
`endif
        end else begin
            if (pop) begin
                if (e0_q.ctr == HALT_CTR) halted_d = 1'b1;
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            if (push) begin
                pc_d = pc_q + 32'd4;
                if (new_e.ctr == HALT_CTR) state_d = ST_HALT;
`ifdef VEDA_IFETCH_BOUNDS_EN
                if (oob) fault_d = 1'b1;
`endif
                // Slot chosen after the same-cycle pop has shifted the buffer.
                if (count_d == 2'd0) e0_d = new_e;
                else                 e1_d = new_e;
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            e0_q     <= '0;
            e1_q     <= '0;
            halted_q <= 1'b0;
`ifdef VEDA_IFETCH_BOUNDS_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            halted_q <= halted_d;
`ifdef VEDA_IFETCH_BOUNDS_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign imem_addr   = (state_q == ST_INIT) ? INIT_ADDR : pc_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_instr   = out_valid ? e0_q.instr   : 32'd0;
    assign out_pc      = out_valid ? e0_q.pc      : 32'd0;
    assign out_ctr     = out_valid ? e0_q.ctr     : 6'd0;
    assign out_funcode = out_valid ? e0_q.funcode : 6'd0;
    assign halted      = halted_q;

endmodule

// File: tb/tb_veda_ifetch.sv
// Bench for veda_ifetch: queue-based fetch model checked every cycle, plus directed literal checks.
module tb_veda_ifetch;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] INIT_A    = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [5:0]  imem_ctr;
  logic [5:0]  imem_funcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_ctr;
  logic [5:0]  out_funcode;
  logic        halted;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [128];

  // model state
  logic [31:0] exp_q[$];
  logic [31:0] m_pc      = 32'd0;
  bit          m_init    = 1'b1;
  bit          m_stopped = 1'b0;
  bit          m_halted  = 1'b0;
  bit          m_fault   = 1'b0;

  logic [31:0] acc_pc_q[$];
  logic [5:0]  acc_ctr_q[$];

  veda_ifetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_ctr(imem_ctr), .imem_funcode(imem_funcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_ctr(out_ctr), .out_funcode(out_funcode),
    .halted(halted), .fault(fault)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a == INIT_A) return HALT_WORD;
    return mem[a[8:2]];
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
`ifdef VEDA_IFETCH_BOUNDS_EN
    return (a[31:2] >= 30'd128);
`else
    return (a == 32'h1234_5678);
`endif
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (is_oob(a)) return HALT_WORD;
    return mem_read(a);
  endfunction

  assign imem_instr   = mem_read(imem_addr);
  assign imem_ctr     = imem_instr[31:26];
  assign imem_funcode = imem_instr[5:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: queue of fetched PCs, advanced on each clock
  initial begin
    logic [31:0] w;
    bit was_full, popped;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_init = 1'b1; m_pc = 32'd0; m_stopped = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
      end else if (m_init) begin
        m_init = 1'b0;
        m_pc   = 32'd0;
      end else begin
        was_full = (exp_q.size() == 2);
        popped   = (exp_q.size() > 0) && out_ready;
        if (redirect_valid) begin
          exp_q.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
          m_stopped = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        end else begin
          if (popped) begin
            w = fetch_word(exp_q[0]);
            if (w[31:26] == 6'h3F) m_halted = 1'b1;
            void'(exp_q.pop_front());
          end
          if (!m_stopped && !was_full) begin
            w = fetch_word(m_pc);
            exp_q.push_back(m_pc);
            if (w[31:26] == 6'h3F) m_stopped = 1'b1;
            if (is_oob(m_pc)) m_fault = 1'b1;
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // compare process: every cycle on the falling edge
  always @(negedge clk) begin
    logic [31:0] w;
    logic [31:0] e_pc;
    bit ev;
    ev   = (exp_q.size() > 0);
    e_pc = ev ? exp_q[0] : 32'd0;
    w    = ev ? fetch_word(e_pc) : 32'd0;
    chk("out_valid",   {31'd0, out_valid}, {31'd0, ev});
    chk("out_pc",      out_pc, e_pc);
    chk("out_instr",   out_instr, w);
    chk("out_ctr",     {26'd0, out_ctr}, {26'd0, w[31:26]});
    chk("out_funcode", {26'd0, out_funcode}, {26'd0, w[5:0]});
    chk("imem_addr",   imem_addr, m_init ? INIT_A : m_pc);
    chk("halted",      {31'd0, halted}, {31'd0, m_halted});
    chk("fault",       {31'd0, fault}, {31'd0, m_fault});
    if (out_valid && out_ready) begin
      acc_pc_q.push_back(out_pc);
      acc_ctr_q.push_back(out_ctr);
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_halt(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (halted) seen = 1'b1;
    end
    chk("halt_wait", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {6'h23, 10'(i), 10'h0, 6'(i)};
    mem[0]  = 32'h2128_000B;
    mem[10] = HALT_WORD;

    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // reset / INIT
    repeat (3) @(negedge clk);
    chk("rst_addr", imem_addr, INIT_A);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    cyc(1);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("first_addr", imem_addr, 32'd0);
    chk("first_valid_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_instr", out_instr, 32'h2128_000B);

    // streaming to halt word at 40
    wait_halt(40);
    chk("stream_count", acc_pc_q.size(), 32'd11);
    for (int i = 0; i < 11 && i < acc_pc_q.size(); i++) chk("stream_pc", acc_pc_q[i], 32'(i * 4));
    if (acc_ctr_q.size() == 11) chk("stream_halt_ctr", {26'd0, acc_ctr_q[10]}, 32'h3F);
    chk("halt_addr", imem_addr, 32'd44);
    cyc(2);
    chk("halt_addr_frozen", imem_addr, 32'd44);

    // redirect out of HALT
    acc_pc_q.delete(); acc_ctr_q.delete();
    do_redirect(32'h4);
    @(negedge clk);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_addr", imem_addr, 32'h4);
    wait_halt(40);
    chk("resume_count", acc_pc_q.size(), 32'd10);
    if (acc_pc_q.size() > 0) chk("resume_first_pc", acc_pc_q[0], 32'h4);

    // asynchronous reset mid-operation, then backpressure
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", imem_addr, INIT_A);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    out_ready = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_pc", out_pc, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    acc_pc_q.delete(); acc_ctr_q.delete();
    cyc(1);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;
    chk("bp_count", acc_pc_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < acc_pc_q.size(); i++) chk("bp_order", acc_pc_q[i], 32'(i * 4));

    // redirect with buffer full
    cyc(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0013;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h10);
    @(negedge clk);
    chk("redir_pc", out_pc, 32'h10);

    // redirect to -4: halt word returned, pc wraps to 0
    cyc(1);
    out_ready = 1'b1;
    do_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_instr", out_instr, HALT_WORD);
    chk("wrap_addr1", imem_addr, 32'd0);
    wait_halt(10);

    // redirect to word 128
    do_redirect(32'h200);
    @(negedge clk);
    chk("oob_addr", imem_addr, 32'h200);
    @(negedge clk);
    chk("oob_pc", out_pc, 32'h200);
`ifdef VEDA_IFETCH_BOUNDS_EN
    chk("oob_instr", out_instr, HALT_WORD);
    chk("oob_fault", {31'd0, fault}, 32'd1);
`else
    chk("oob_instr", out_instr, 32'h2128_000B);
    chk("oob_fault", {31'd0, fault}, 32'd0);
`endif
    wait_halt(30);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
